// File: rtl/scan_pkg.sv
// Shared scan-protocol definitions used by the BIST controller and the CUT-side responder.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } scan_state_t;

  localparam int   SCAN_CHAIN_LEN = 263;
  localparam logic SCAN_SHIFT     = 1'b1;
  localparam logic SCAN_CAPTURE   = 1'b0;

endpackage

// File: rtl/scan_cell.sv
// Mux-D scan flop: loads si when se=1, the functional d otherwise; holds when en=0.
module scan_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic se,
  input  logic si,
  input  logic d,
  output logic q
);

  // Scan/functional flop with hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= se ? si : d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/scan_chain_responder.sv
// CUT-side scan responder: mux-D chain plus protocol FSM, shift/capture counters
// and sticky errors flagging loads that were not exactly CHAIN_LEN bits long.
module scan_chain_responder
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
  parameter int CNT_W     = 16,
  parameter int SHIFT_W   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bistmode,
  input  logic                 cut_scanmode,
  input  logic                 cut_sdi,
  output logic                 cut_sdo,
  output logic [CHAIN_LEN-1:0] func_pi,
  input  logic [CHAIN_LEN-1:0] func_po,
  output logic                 capture_pulse,
  output logic [CNT_W-1:0]     capture_cnt,
  output logic [SHIFT_W-1:0]   shift_cnt,
  output logic                 err_short,
  output logic                 err_long
);

  localparam logic [SHIFT_W-1:0] LEN_CNT   = SHIFT_W'(CHAIN_LEN);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = {SHIFT_W{1'b1}};
  localparam logic [SHIFT_W-1:0] SHIFT_ONE = {{(SHIFT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  scan_state_t          state;
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] shift_in;
  logic                 do_shift;
  logic                 do_capture;
  logic [SHIFT_W-1:0]   shift_inc;

  assign shift_in = {cut_sdi, chain[CHAIN_LEN-1:1]};
  assign cut_sdo  = chain[0];
  assign func_pi  = chain;

  // Decode this cycle's chain operation; a capture only follows a shift
  always_comb begin
    do_shift   = 1'b0;
    do_capture = 1'b0;
    if (bistmode) begin
      if (cut_scanmode == SCAN_SHIFT) begin
        do_shift = 1'b1;
      end else if (state == SHIFT) begin
        do_capture = 1'b1;
      end else begin
        do_capture = 1'b0;
      end
    end else begin
      do_shift   = 1'b0;
      do_capture = 1'b0;
    end
  end

  // Saturating shift count so a runaway controller cannot wrap back to a legal value
  always_comb begin
    if (shift_cnt == SHIFT_MAX) begin
      shift_inc = shift_cnt;
    end else begin
      shift_inc = shift_cnt + SHIFT_ONE;
    end
  end

  for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_cell
    scan_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (do_shift | do_capture),
      .se  (do_shift),
      .si  (shift_in[i]),
      .d   (func_po[i]),
      .q   (chain[i])
    );
  end

  // Protocol FSM with counters and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      capture_pulse <= 1'b0;
      capture_cnt   <= {CNT_W{1'b0}};
      shift_cnt     <= {SHIFT_W{1'b0}};
      err_short     <= 1'b0;
      err_long      <= 1'b0;
    end else if (!bistmode) begin
      // Counters and flags stay frozen for readout after the session
      state         <= IDLE;
      capture_pulse <= 1'b0;
    end else begin
      capture_pulse <= 1'b0;
      case (state)
        IDLE: begin
          capture_cnt <= {CNT_W{1'b0}};
          err_short   <= 1'b0;
          err_long    <= 1'b0;
          if (cut_scanmode == SCAN_SHIFT) begin
            state     <= SHIFT;
            shift_cnt <= SHIFT_ONE;
          end else begin
            state     <= HOLD;
            shift_cnt <= {SHIFT_W{1'b0}};
          end
        end
        SHIFT: begin
          if (do_shift) begin
            shift_cnt <= shift_inc;
            if (shift_cnt >= LEN_CNT) begin
              err_long <= 1'b1;
            end else begin
              err_long <= err_long;
            end
          end else begin
            state         <= CAPTURE;
            capture_pulse <= 1'b1;
            capture_cnt   <= capture_cnt + CNT_ONE;
            shift_cnt     <= {SHIFT_W{1'b0}};
            if (shift_cnt < LEN_CNT) begin
              err_short <= 1'b1;
            end else begin
              err_short <= err_short;
            end
          end
        end
        CAPTURE, HOLD: begin
          if (do_shift) begin
            state     <= SHIFT;
            shift_cnt <= shift_inc;
            if (shift_cnt >= LEN_CNT) begin
              err_long <= 1'b1;
            end else begin
              err_long <= err_long;
            end
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_responder.sv
// Randomized self-checking bench for scan_chain_responder against a session-level model.
module tb_scan_chain_responder;

  localparam int L  = 8;
  localparam int CW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst, bistmode, cut_scanmode, cut_sdi;
  logic          cut_sdo, capture_pulse, err_short, err_long;
  logic [L-1:0]  func_pi, func_po;
  logic [CW-1:0] capture_cnt;
  logic [SW-1:0] shift_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a session is active while bistmode stays high; capture
  // is allowed only if the previous in-session cycle shifted.
  logic [L-1:0] m_chain;
  int           m_cap, m_shift;
  bit           m_es, m_el, m_pulse, m_active, m_can_cap;

  scan_chain_responder #(.CHAIN_LEN(L), .CNT_W(CW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst), .bistmode(bistmode), .cut_scanmode(cut_scanmode),
    .cut_sdi(cut_sdi), .cut_sdo(cut_sdo), .func_pi(func_pi), .func_po(func_po),
    .capture_pulse(capture_pulse), .capture_cnt(capture_cnt), .shift_cnt(shift_cnt),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_chain = '0; m_cap = 0; m_shift = 0; m_es = 0; m_el = 0;
      m_pulse = 0; m_active = 0; m_can_cap = 0;
    end else if (!bistmode) begin
      m_active = 0; m_pulse = 0;
    end else begin
      if (!m_active) begin
        m_cap = 0; m_shift = 0; m_es = 0; m_el = 0; m_can_cap = 0; m_active = 1;
      end
      m_pulse = 0;
      if (cut_scanmode) begin
        if (m_shift + 1 > L) m_el = 1;
        m_shift = (m_shift + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_shift + 1;
        m_chain = {cut_sdi, m_chain[L-1:1]};
        m_can_cap = 1;
      end else if (m_can_cap) begin
        m_chain = func_po; m_pulse = 1; m_cap = (m_cap + 1) % (1 << CW);
        if (m_shift < L) m_es = 1;
        m_shift = 0; m_can_cap = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("cut_sdo", 32'(cut_sdo), 32'(m_chain[0]));
    check("func_pi", 32'(func_pi), 32'(m_chain));
    check("capture_pulse", 32'(capture_pulse), 32'(m_pulse));
    check("capture_cnt", 32'(capture_cnt), 32'(m_cap));
    check("shift_cnt", 32'(shift_cnt), 32'(m_shift));
    check("err_short", 32'(err_short), 32'(m_es));
    check("err_long", 32'(err_long), 32'(m_el));
  endtask

  task automatic cyc(input logic r, input logic b, input logic sm, input logic sdi,
                     input logic [L-1:0] po);
    rst = r; bistmode = b; cut_scanmode = sm; cut_sdi = sdi; func_po = po;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic shift_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  initial begin
    logic [L-1:0] pat;
    logic [L-1:0] seq;
    rst = 1'b1; bistmode = 1'b0; cut_scanmode = 1'b0; cut_sdi = 1'b0; func_po = '0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Make the chain nonzero, then reset
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    check("preload_nonzero", 32'(func_pi), 32'hFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    check("reset_pi", 32'(func_pi), 32'h0);
    check("reset_sdo", 32'(cut_sdo), 32'h0);
    check("reset_cnt", 32'(capture_cnt), 32'h0);

    // Shift-through of 8'hB2 LSB first
    pat = 8'hB2;
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 1'b1, pat[i], 8'h00);
    check("load_b2", 32'(func_pi), 32'hB2);
    check("load_shift_cnt", 32'(shift_cnt), 32'd8);
    check("load_no_err", 32'({err_short, err_long}), 32'h0);

    // Capture 8'h5A, then unload it
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    check("cap_pi", 32'(func_pi), 32'h5A);
    check("cap_pulse", 32'(capture_pulse), 32'h1);
    check("cap_cnt", 32'(capture_cnt), 32'd1);
    check("cap_shift_cnt", 32'(shift_cnt), 32'd0);
    seq = 8'h5A;
    for (int i = 0; i < L; i++) begin
      check("unload_sdo", 32'(cut_sdo), 32'(seq[i]));
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    end

    // Hold: only the first of three capture cycles loads the chain
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
    check("hold_pulse_once", 32'(capture_pulse), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    check("hold_pi", 32'(func_pi), 32'h11);
    check("hold_cnt", 32'(capture_cnt), 32'd2);

    // Short load, sticky across a good pattern
    shift_n(5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    check("err_short_set", 32'(err_short), 32'h1);
    shift_n(L);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    check("err_short_sticky", 32'(err_short), 32'h1);
    // Long load
    shift_n(L + 1);
    check("err_long_set", 32'(err_long), 32'h1);
    // New session clears the flags
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    check("session_clear", 32'({err_short, err_long}), 32'h0);
    check("session_shift_cnt", 32'(shift_cnt), 32'd1);

    // Reset mid-shift
    shift_n(3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    check("midrst_pi", 32'(func_pi), 32'h0);
    check("midrst_shift_cnt", 32'(shift_cnt), 32'h0);

    // bistmode drop mid-shift freezes everything without a flag
    shift_n(4);
    pat = func_pi;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    check("drop_pi_frozen", 32'(func_pi), 32'(pat));
    check("drop_shift_cnt", 32'(shift_cnt), 32'd4);
    check("drop_no_err", 32'({err_short, err_long}), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 29) != 0),
          1'($urandom_range(0, 9) < 8),
          1'($urandom_range(0, 1)),
          8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_responder.md
Name: scan_chain_responder

Overview:
- CUT-side end of the BIST scan protocol. Receives cut_scanmode/cut_sdi from the BIST controller and returns cut_sdo.
- Implements a CHAIN_LEN-bit mux-D scan chain: its bits drive the CUT primary inputs, and it captures CUT primary outputs once per pattern.
- Adds an FSM, shift/capture counters and sticky protocol-error flags, so benches and silicon debug can confirm the controller shifted exactly CHAIN_LEN bits per pattern.

Parameters:
- CHAIN_LEN, 263, scan chain length in bits; must be ≥ 2.
- CNT_W, 16, width of the pattern counter (capture_cnt).
- SHIFT_W, 9, width of the shift counter; must satisfy 2^SHIFT_W > CHAIN_LEN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- bistmode  input  1  BIST session active; 0 forces IDLE
- cut_scanmode  input  1  1 = shift, 0 = capture/hold
- cut_sdi  input  1  serial scan data in
- cut_sdo  output  1  serial scan data out (chain[0])
- func_pi  output  CHAIN_LEN  chain contents driven to CUT inputs
- func_po  input  CHAIN_LEN  CUT response, captured into the chain
- capture_pulse  output  1  one-cycle strobe on the cycle a capture occurs
- capture_cnt  output  CNT_W  number of captures this session
- shift_cnt  output  SHIFT_W  bits shifted since the last capture/session start
- err_short  output  1  sticky: capture with shift_cnt < CHAIN_LEN
- err_long  output  1  sticky: shift_cnt exceeded CHAIN_LEN before a capture

Behaviour:
- Reset (rst=1 at posedge clk): chain = 0, state = IDLE, capture_cnt = 0, shift_cnt = 0, err_short = err_long = 0, capture_pulse = 0. Consequently cut_sdo = 0 and func_pi = 0. Reset overrides everything, including mid-shift.
- Chain orientation:
  - Shift: chain <= {cut_sdi, chain[CHAIN_LEN-1:1]}.
  - cut_sdo = chain[0], a flop output with no combinational path from cut_sdi.
  - func_pi = chain, continuously.
- FSM states: IDLE, SHIFT, CAPTURE, HOLD, evaluated on each posedge.
  - IDLE:
    - bistmode=1 & cut_scanmode=1 -> SHIFT, and this cycle performs a shift with shift_cnt <= 1.
    - bistmode=1 & cut_scanmode=0 -> HOLD; no capture before the first load.
    - Entering a session from IDLE clears capture_cnt, shift_cnt and the err flags.
  - SHIFT, cut_scanmode=1:
    - Shift and increment shift_cnt, saturating at 2^SHIFT_W-1.
    - If shift_cnt becomes CHAIN_LEN+1, set err_long.
  - SHIFT, cut_scanmode=0 -> CAPTURE cycle:
    - chain <= func_po; capture_pulse = 1 on the following cycle.
    - capture_cnt increments, wrapping modulo 2^CNT_W.
    - If shift_cnt < CHAIN_LEN, set err_short; then shift_cnt <= 0.
  - CAPTURE:
    - cut_scanmode=1 -> SHIFT with a shift (shift_cnt <= 1).
    - cut_scanmode=0 -> HOLD.
  - HOLD:
    - Chain frozen; no further capture, so at most one capture per load.
    - cut_scanmode=1 -> SHIFT with a shift.
  - Any state, bistmode=0 -> IDLE; the chain holds its value and the counters/flags hold for readout.
- Final unload: the controller may shift fewer than CHAIN_LEN bits and then drop bistmode. This is legal and sets no flag.
- Simultaneous events: bistmode=0 has priority over cut_scanmode. rst has priority over all.
- Latency:
  - Bit driven on cut_sdi at edge N appears at cut_sdo after CHAIN_LEN edges.
  - A captured func_po[0] appears on cut_sdo the cycle after capture.

Decomposition:
- Shared package scan_pkg: state enum (IDLE/SHIFT/CAPTURE/HOLD), default CHAIN_LEN=263 shared with the BIST controller, shift-mode encodings (SCAN_SHIFT=1, SCAN_CAPTURE=0).
- One sub-module, scan_cell (mux-D flop: se, si, d, q), generated CHAIN_LEN times. The FSM and counters stay in the top.

Test Plan (CHAIN_LEN=8, SHIFT_W=4):
- Reset: rst=1 one cycle with the chain previously nonzero -> cut_sdo=0, func_pi=0, counters 0, state IDLE.
- Shift-through: bistmode=1, scanmode=1, shift 8'b1011_0010 LSB-first for 8 cycles -> func_pi=8'hB2, shift_cnt=8, no err; cut_sdo shows the old chain bits in order.
- Capture: after the load, scanmode=0 for 1 cycle with func_po=8'h5A -> chain=8'h5A, capture_pulse=1 for 1 cycle, capture_cnt=1, shift_cnt=0. Shift 8 more -> cut_sdo sequence 0,1,0,1,1,0,1,0.
- Hold: scanmode=0 for 3 consecutive cycles with func_po changing -> only the first func_po is captured, capture_cnt +1 only, state HOLD.
- Errors:
  - Capture after 5 shifts -> err_short=1 (sticky across later good patterns).
  - 9 shifts without capture -> err_long=1.
  - bistmode 0->1 clears both.
- Mid-shift disruption: rst=1 at shift 4 -> all outputs reset values. Separately, bistmode=0 at shift 4 -> chain/counters frozen, no flag set.
